// File: rtl/cp0_defs.sv
// Shared CP0 constants: register numbers, exception codes, except[] bit
// indices and Status/Cause field positions.
package cp0_defs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EX_ERET    = 0;
  localparam int EX_INT     = 1;
  localparam int EX_ADEL_IF = 2;
  localparam int EX_RI      = 3;
  localparam int EX_OV      = 4;
  localparam int EX_SYS     = 5;
  localparam int EX_BP      = 6;
  localparam int EX_ADEL_LD = 7;
  localparam int EX_ADES    = 8;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  localparam int CA_BD = 31;
  localparam int CA_TI = 30;

  // Status bits software may change: IM[15:8], EXL, IE.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_ADDR = 2'd2
  } badv_sel_e;

endpackage

// File: rtl/cp0_exc_encode.sv
// Priority encoder for except[8:1]: the lowest set bit selects the ExcCode
// and where BadVAddr is loaded from.
module cp0_exc_encode
  import cp0_defs::*;
(
  input  logic [8:1]  i_except,
  output logic        o_valid,
  output logic [4:0]  o_exccode,
  output badv_sel_e   o_badv_sel
);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    o_valid    = |i_except;
    o_exccode  = EXC_INT;
    o_badv_sel = BADV_NONE;
    if (i_except[EX_INT]) begin
      o_exccode = EXC_INT;
    end else if (i_except[EX_ADEL_IF]) begin
      o_exccode  = EXC_ADEL;
      o_badv_sel = BADV_PC;
    end else if (i_except[EX_RI]) begin
      o_exccode = EXC_RI;
    end else if (i_except[EX_OV]) begin
      o_exccode = EXC_OV;
    end else if (i_except[EX_SYS]) begin
      o_exccode = EXC_SYS;
    end else if (i_except[EX_BP]) begin
      o_exccode = EXC_BP;
    end else if (i_except[EX_ADEL_LD]) begin
      o_exccode  = EXC_ADEL;
      o_badv_sel = BADV_ADDR;
    end else if (i_except[EX_ADES]) begin
      o_exccode  = EXC_ADES;
      o_badv_sel = BADV_ADDR;
    end
  end

endmodule

// File: rtl/mem_cp0_regs.sv
// MEM-stage CP0 register file: EPC, BadVAddr, Count, Compare, Status, Cause,
// exception/ERET commit, Count/Compare timer and interrupt request.
module mem_cp0_regs
  import cp0_defs::*;
#(
  parameter int unsigned  COUNT_DIV    = 2,
  parameter logic [31:0]  RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  except,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_badvaddr,
  input  logic        in_delay_slot,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic        int_req,
  output logic        exc_flush
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]      r_status, r_epc, r_badvaddr, r_count, r_compare;
  logic             r_cause_bd, r_cause_ti;
  logic [7:0]       r_cause_ip;
  logic [4:0]       r_cause_exc;
  logic [DIV_W-1:0] r_div;
  logic             r_count_written;

  logic             w_enc_valid;
  logic [4:0]       w_enc_code;
  badv_sel_e        w_badv_sel;
  logic             w_eret, w_exc, w_mtc0;
  logic             w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
  logic             w_tick, w_match, w_ti_next;
  logic [31:0]      w_cause;

  cp0_exc_encode u_encode (
    .i_except   (except[8:1]),
    .o_valid    (w_enc_valid),
    .o_exccode  (w_enc_code),
    .o_badv_sel (w_badv_sel)
  );

  assign w_eret       = except[EX_ERET];
  assign w_exc        = w_enc_valid & ~w_eret;
  assign w_mtc0       = mtc0_we & ~(|except);
  assign w_wr_count   = w_mtc0 && (cp0_addr == REG_COUNT);
  assign w_wr_compare = w_mtc0 && (cp0_addr == REG_COMPARE);
  assign w_wr_status  = w_mtc0 && (cp0_addr == REG_STATUS);
  assign w_wr_cause   = w_mtc0 && (cp0_addr == REG_CAUSE);
  assign w_wr_epc     = w_mtc0 && (cp0_addr == REG_EPC);

  assign w_tick    = (r_div == DIV_W'(COUNT_DIV - 1));
  // A 0==0 match straight out of reset must not fire the timer.
  assign w_match   = (r_count == r_compare) && ((r_compare != 32'd0) || r_count_written);
  assign w_ti_next = w_wr_compare ? 1'b0 : (w_match ? 1'b1 : r_cause_ti);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= RESET_STATUS;
    end else if (w_eret) begin
      r_status[ST_EXL] <= 1'b0;
    end else if (w_exc) begin
      r_status[ST_EXL] <= 1'b1;
    end else if (w_wr_status) begin
      r_status <= (r_status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_epc       <= '0;
      r_badvaddr  <= '0;
      r_cause_bd  <= 1'b0;
      r_cause_exc <= '0;
    end else if (w_exc) begin
      r_cause_exc <= w_enc_code;
      // Nested exceptions keep the original return address and BD flag.
      if (!r_status[ST_EXL]) begin
        r_epc      <= in_delay_slot ? (ex_pc - 32'd4) : ex_pc;
        r_cause_bd <= in_delay_slot;
      end
      case (w_badv_sel)
        BADV_PC:   r_badvaddr <= ex_pc;
        BADV_ADDR: r_badvaddr <= ex_badvaddr;
        default:   r_badvaddr <= r_badvaddr;
      endcase
    end else if (w_wr_epc) begin
      r_epc <= cp0_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause_ti <= 1'b0;
      r_cause_ip <= '0;
    end else begin
      r_cause_ti      <= w_ti_next;
      r_cause_ip[7:2] <= {hw_int[5] | w_ti_next, hw_int[4:0]};
      if (w_wr_cause) r_cause_ip[1:0] <= cp0_wdata[9:8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count         <= '0;
      r_compare       <= '0;
      r_div           <= '0;
      r_count_written <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count         <= cp0_wdata;
        r_div           <= '0;
        r_count_written <= 1'b1;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
        r_div   <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_wr_compare) r_compare <= cp0_wdata;
    end
  end

  assign w_cause = {r_cause_bd, r_cause_ti, 14'd0, r_cause_ip, 1'b0, r_cause_exc, 2'b00};

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_BADVADDR: cp0_rdata = r_badvaddr;
      REG_COUNT:    cp0_rdata = r_count;
      REG_COMPARE:  cp0_rdata = r_compare;
      REG_STATUS:   cp0_rdata = r_status;
      REG_CAUSE:    cp0_rdata = w_cause;
      REG_EPC:      cp0_rdata = r_epc;
      default:      cp0_rdata = '0;
    endcase
  end

  assign epc       = r_epc;
  assign status    = r_status;
  assign cause     = w_cause;
  assign int_req   = (|(r_cause_ip & r_status[ST_IM_HI:ST_IM_LO]))
                     & r_status[ST_IE] & ~r_status[ST_EXL];
  assign exc_flush = |except;

endmodule

// File: tb/tb_mem_cp0_regs.sv
// Directed bench for mem_cp0_regs: a behavioural CP0 model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_cp0_regs;

  localparam int unsigned COUNT_DIV = 2;
  localparam logic [31:0] RST_STATUS = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  except;
  logic [31:0] ex_pc, ex_badvaddr, cp0_wdata, cp0_rdata, epc, status, cause;
  logic        in_delay_slot, mtc0_we, int_req, exc_flush;
  logic [4:0]  cp0_addr;
  logic [5:0]  hw_int;

  int n_checks = 0;
  int n_fail   = 0;

  mem_cp0_regs #(.COUNT_DIV(COUNT_DIV), .RESET_STATUS(RST_STATUS)) dut (
    .clk(clk), .resetn(resetn), .except(except), .ex_pc(ex_pc),
    .ex_badvaddr(ex_badvaddr), .in_delay_slot(in_delay_slot),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .hw_int(hw_int), .epc(epc), .status(status),
    .cause(cause), .int_req(int_req), .exc_flush(exc_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_status, m_epc, m_badv, m_compare, m_base;
  int          m_edges;
  logic        m_bd, m_ti, m_cnt_wr;
  logic [7:0]  m_ip;
  logic [4:0]  m_code;
  logic        t_match, t_mt;
  int          t_win;

  // Count is the last written value plus one per COUNT_DIV edges since then.
  function automatic logic [31:0] m_count();
    return m_base + 32'(m_edges / int'(COUNT_DIV));
  endfunction

  function automatic logic [4:0] code_of(input int b);
    case (b)
      1: return 5'h00;  2: return 5'h04;  3: return 5'h0a;  4: return 5'h0c;
      5: return 5'h08;  6: return 5'h09;  7: return 5'h04;  default: return 5'h05;
    endcase
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_status = RST_STATUS; m_epc = 0; m_badv = 0; m_compare = 0; m_base = 0;
      m_edges = 0; m_bd = 0; m_ti = 0; m_cnt_wr = 0; m_ip = 0; m_code = 0;
    end else begin
      t_mt    = mtc0_we && (except == 9'd0);
      t_match = (m_count() == m_compare) && (m_compare != 0 || m_cnt_wr);
      if (t_mt && cp0_addr == 5'd9) begin
        m_base = cp0_wdata; m_edges = 0; m_cnt_wr = 1;
      end else begin
        m_edges++;
      end
      if (t_mt && cp0_addr == 5'd11) m_ti = 0;
      else if (t_match)              m_ti = 1;
      m_ip[7:2] = {hw_int[5] | m_ti, hw_int[4:0]};
      if (except[0]) begin
        m_status[1] = 1'b0;
      end else if (except[8:1] != 0) begin
        t_win = 0;
        for (int i = 8; i >= 1; i--) if (except[i]) t_win = i;
        m_code = code_of(t_win);
        if (!m_status[1]) begin
          m_epc = in_delay_slot ? ex_pc - 4 : ex_pc;
          m_bd  = in_delay_slot;
        end
        m_status[1] = 1'b1;
        if (t_win == 2) m_badv = ex_pc;
        else if (t_win == 7 || t_win == 8) m_badv = ex_badvaddr;
      end else if (t_mt) begin
        case (cp0_addr)
          5'd11: m_compare = cp0_wdata;
          5'd12: begin
            m_status[15:8] = cp0_wdata[15:8];
            m_status[1:0]  = cp0_wdata[1:0];
          end
          5'd13: m_ip[1:0] = cp0_wdata[9:8];
          5'd14: m_epc = cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      check("cyc_epc", epc, m_epc);
      check("cyc_status", status, m_status);
      check("cyc_cause", cause, m_cause());
      check("cyc_rdata", cp0_rdata, m_rdata(cp0_addr));
      check("cyc_int_req", 32'(int_req),
            32'((|(m_ip & m_status[15:8])) & m_status[0] & ~m_status[1]));
      check("cyc_exc_flush", 32'(exc_flush), 32'(except != 9'd0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
  endtask

  int n_edges;

  initial begin
    resetn = 0; except = 0; ex_pc = 0; ex_badvaddr = 0; in_delay_slot = 0;
    mtc0_we = 0; cp0_addr = 0; cp0_wdata = 0; hw_int = 0;
    #11;
    check("rst_status", status, 32'h0040_0000);
    check("rst_cause", cause, 32'h0);
    #1 resetn = 1;
    tick(); tick();

    // Syscall, then ERET
    except = 9'h020; ex_pc = 32'hbfc0_0100; in_delay_slot = 0;
    #1 check("sys_flush", 32'(exc_flush), 32'd1);
    tick();
    check("sys_epc", epc, 32'hbfc0_0100);
    check("sys_code", 32'(cause[6:2]), 32'h08);
    check("sys_exl", 32'(status[1]), 32'd1);
    except = 9'h001;
    tick();
    check("eret_exl", 32'(status[1]), 32'd0);
    check("eret_epc", epc, 32'hbfc0_0100);

    // Delay-slot Ov, then nested RI
    except = 9'h010; in_delay_slot = 1; ex_pc = 32'h80;
    tick();
    check("ov_epc", epc, 32'h7c);
    check("ov_bd", 32'(cause[31]), 32'd1);
    check("ov_code", 32'(cause[6:2]), 32'h0c);
    except = 9'h008; in_delay_slot = 0; ex_pc = 32'h200;
    tick();
    check("nest_epc", epc, 32'h7c);
    check("nest_code", 32'(cause[6:2]), 32'h0a);
    check("nest_bd", 32'(cause[31]), 32'd1);
    except = 9'h001;
    tick();

    // AdES with a coincident MTC0 EPC that must be dropped
    except = 9'h100; ex_badvaddr = 32'h1003; ex_pc = 32'h300;
    mtc0(5'd14, 32'hdead);
    tick();
    mtc0_we = 0; cp0_addr = 5'd8;
    // ERET+Int: only EXL clears
    except = 9'h003; ex_pc = 32'h400;
    #1 check("ades_badv", cp0_rdata, 32'h1003);
    check("ades_code", 32'(cause[6:2]), 32'h05);
    check("ades_epc", epc, 32'h300);
    tick();
    check("eretint_exl", 32'(status[1]), 32'd0);
    check("eretint_epc", epc, 32'h300);
    check("eretint_code", 32'(cause[6:2]), 32'h05);
    // Sys (bit5) beats AdEL-load (bit7)
    except = 9'h0a0; ex_pc = 32'h500; ex_badvaddr = 32'h9999;
    tick();
    check("prio_code", 32'(cause[6:2]), 32'h08);
    check("prio_epc", epc, 32'h500);
    check("prio_badv", cp0_rdata, 32'h1003);
    except = 9'h001;
    tick();
    except = 0;

    // Timer
    mtc0(5'd9, 32'h100);  tick();
    mtc0(5'd11, 32'd5);   tick();
    mtc0(5'd9, 32'd0);    tick();
    mtc0(5'd12, 32'h0000_ff01);
    n_edges = 1;
    tick();
    mtc0_we = 0; cp0_addr = 5'd9;
    while (!cause[30] && n_edges < 40) begin
      tick();
      n_edges++;
    end
    check("timer_edges", 32'(n_edges), 32'd11);
    check("timer_int_req", 32'(int_req), 32'd1);
    check("timer_count", cp0_rdata, 32'd5);
    mtc0(5'd11, 32'h1000);
    tick();
    mtc0_we = 0;
    check("cmp_clr_ti", 32'(cause[30]), 32'd0);
    check("cmp_clr_int", 32'(int_req), 32'd0);
    hw_int = 6'b000001;
    tick();
    check("hw_int_req", 32'(int_req), 32'd1);

    // Count wrap
    mtc0(5'd9, 32'hffff_ffff);
    tick();
    mtc0_we = 0; cp0_addr = 5'd9;
    tick();
    check("wrap_pre", cp0_rdata, 32'hffff_ffff);
    tick();
    check("wrap_post", cp0_rdata, 32'd0);

    // Read-only BadVAddr, Cause IP[9:8] write, register read sweep
    mtc0(5'd8, 32'h1234_5678); tick();
    mtc0(5'd13, 32'hffff_ffff); tick();
    mtc0_we = 0;
    check("cause_ip_sw", 32'(cause[9:8]), 32'h3);
    for (int a = 0; a < 32; a++) begin
      cp0_addr = 5'(a);
      tick();
    end

    // Asynchronous reset mid-cycle
    check("pre_rst_int", 32'(int_req), 32'd1);
    #2 resetn = 0;
    #1;
    check("arst_status", status, 32'h0040_0000);
    check("arst_cause", cause, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_int_req", 32'(int_req), 32'd0);
    check("arst_rdata", cp0_rdata, 32'h0);
    @(negedge clk);
    #2 resetn = 1;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
